leds_sevseg_ctrl: RTL
=====================

Name: leds_sevseg_ctrl

Overview:
Parametrised memory-mapped LED and seven-segment register block on the CPU write bus, adding read-back, per-digit blinking and PWM brightness.
- Holds the LED bank, packed BCD/hex digit nibbles, a control register and a blink-period register.
- Drives decoded-ready nibbles plus a per-digit blank mask to the downstream 7-seg decoders.
- Drives the PWM-gated, blink-gated LED bank directly.

Parameters:
NUM_LEDS, 10, LED bank width, 1..32
NUM_DIGITS, 6, number of 4-bit digits, 1..8
BLINK_W, 24, width of the blink prescaler and period register, 8..32
RST_PERIOD, 24'd12_500_000, reset value of the blink-period register

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
addr  in  32  byte address; only addr[4:2] decoded
select  in  1  block chip-select
wr_en  in  1  write strobe, one cycle per write
rd_en  in  1  read strobe, one cycle per read
data_in  in  32  write data
rd_data  out  32  read data, valid when rd_valid=1
rd_valid  out  1  one-cycle read-response pulse
leds_out  out  NUM_LEDS  LED drive after PWM and blink gating
sevseg_out  out  4*NUM_DIGITS  digit nibbles; digit i at [4i+3:4i]
digit_blank  out  NUM_DIGITS  1 = digit i must be blanked (blink off-phase or PWM off)

Behaviour:
- Register map (offset = addr[4:2]):
  - 3'b100 LED: NUM_LEDS bits, from data_in[NUM_LEDS-1:0].
  - 3'b101 DIGITS: 4*NUM_DIGITS bits, from data_in[4*NUM_DIGITS-1:0].
  - 3'b110 CTRL: [NUM_DIGITS-1:0] = digit blink mask; [8] = LED blink enable; [15:12] = brightness.
  - 3'b111 PERIOD: BLINK_W bits.
  - Other offsets: writes ignored, reads return 0.
- Writes: take effect at the clk edge where wr_en & select; new value is visible on outputs the next cycle. Unused data_in bits are ignored.
- Reads: rd_en & select at edge N gives rd_valid=1 and rd_data (register zero-extended) during cycle N+1. Otherwise rd_valid=0 and rd_data holds its last value.
- Read and write in the same cycle to the same offset: read returns the old value.
- Reset values: LED=0, DIGITS=0, CTRL=0x0000F000 (brightness 15, no blink), PERIOD=RST_PERIOD, prescaler=RST_PERIOD, blink_phase=0, pwm_cnt=0, rd_data=0, rd_valid=0.
- Reset is asynchronous; asserting it mid-operation returns every register and output to its reset value immediately.
- Blink prescaler (down-counter):
  - Each cycle: if 0, reload with PERIOD and toggle blink_phase; else decrement.
  - PERIOD==0: prescaler held at 0 and blink_phase forced to 0 (never off).
  - A write to PERIOD reloads the prescaler with the new value on the same edge; blink_phase is unchanged.
- PWM:
  - 4-bit pwm_cnt free-runs 0..15 and wraps.
  - pwm_on = (brightness==15) | (pwm_cnt < brightness), registered.
  - brightness 0 gives permanently off; brightness 15 gives permanently on.
- Outputs, all registered (one cycle after the internal state):
  - leds_out = LED & {NUM_LEDS{pwm_on & ~(CTRL[8] & blink_phase)}}.
  - digit_blank[i] = ~pwm_on | (CTRL[i] & blink_phase).
  - sevseg_out = DIGITS, unmodified.

Test Plan:
- Reset, then read offset 3'b110 -> rd_valid pulses one cycle after the strobe, rd_data=0x0000F000; leds_out=0, sevseg_out=0, digit_blank=0.
- Write LED=0x3FF, then DIGITS=0x00654321 -> leds_out=0x3FF and sevseg_out=0x654321 one cycle after each write; read-back returns the same values.
- PERIOD=4, CTRL=0x0000F101 -> leds_out and digit_blank[0] toggle every 5 cycles; digit_blank[5:1]=0.
- CTRL brightness=4, no blink -> over 16 consecutive cycles leds_out=0x3FF exactly 4 times and digit_blank=all-ones exactly 12 times; brightness=0 gives always off.
- Write to offset 3'b000, and a simultaneous read+write of LED (old 0x001, new 0x002) -> no register changes from the unmapped write; read returns 0x001, then a later read returns 0x002.
- Assert rst_n mid-blink with PERIOD=4 -> all outputs 0 asynchronously; after release, PERIOD reads RST_PERIOD.

Source files
------------

// File: rtl/leds_sevseg_ctrl.sv
// rtl/leds_sevseg_ctrl.sv - memory-mapped LED bank and seven-segment register block
// Adds read-back, per-digit blinking and PWM brightness gating.
module leds_sevseg_ctrl #(
  parameter int                 NUM_LEDS   = 10,
  parameter int                 NUM_DIGITS = 6,
  parameter int                 BLINK_W    = 24,
  parameter logic [BLINK_W-1:0] RST_PERIOD = BLINK_W'(12_500_000)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [31:0]             addr,
  input  logic                    select,
  input  logic                    wr_en,
  input  logic                    rd_en,
  input  logic [31:0]             data_in,
  output logic [31:0]             rd_data,
  output logic                    rd_valid,
  output logic [NUM_LEDS-1:0]     leds_out,
  output logic [4*NUM_DIGITS-1:0] sevseg_out,
  output logic [NUM_DIGITS-1:0]   digit_blank
);

  localparam logic [2:0] OFF_LED    = 3'b100;
  localparam logic [2:0] OFF_DIGITS = 3'b101;
  localparam logic [2:0] OFF_CTRL   = 3'b110;
  localparam logic [2:0] OFF_PERIOD = 3'b111;

  logic [2:0]              offset;
  logic                    wr_hit;
  logic                    rd_hit;
  logic [NUM_LEDS-1:0]     led_reg;
  logic [4*NUM_DIGITS-1:0] digits_reg;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic                    led_blink;
  logic [3:0]              brightness;
  logic [BLINK_W-1:0]      period_reg;
  logic [BLINK_W-1:0]      prescaler;
  logic                    blink_phase;
  logic [3:0]              pwm_cnt;
  logic                    pwm_on;
  logic [31:0]             rd_mux;
  logic                    unused_bits;

  assign offset      = addr[4:2];
  assign wr_hit      = wr_en & select;
  assign rd_hit      = rd_en & select;
  assign unused_bits = ^{addr[31:5], addr[1:0], data_in};

  always_comb begin
    rd_mux = '0;
    case (offset)
      OFF_LED:    rd_mux[NUM_LEDS-1:0]     = led_reg;
      OFF_DIGITS: rd_mux[4*NUM_DIGITS-1:0] = digits_reg;
      OFF_CTRL: begin
        rd_mux[NUM_DIGITS-1:0] = blink_mask;
        rd_mux[8]              = led_blink;
        rd_mux[15:12]          = brightness;
      end
      OFF_PERIOD: rd_mux[BLINK_W-1:0]      = period_reg;
      default:    rd_mux                   = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_reg    <= '0;
      digits_reg <= '0;
      blink_mask <= '0;
      led_blink  <= 1'b0;
      brightness <= 4'hF;
      period_reg <= RST_PERIOD;
    end else if (wr_hit) begin
      case (offset)
        OFF_LED:    led_reg    <= data_in[NUM_LEDS-1:0];
        OFF_DIGITS: digits_reg <= data_in[4*NUM_DIGITS-1:0];
        OFF_CTRL: begin
          blink_mask <= data_in[NUM_DIGITS-1:0];
          led_blink  <= data_in[8];
          brightness <= data_in[15:12];
        end
        OFF_PERIOD: period_reg <= data_in[BLINK_W-1:0];
        default: ;
      endcase
    end
  end

  // Read data is taken from the pre-edge registers, so a same-cycle write is not seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_hit;
      if (rd_hit) rd_data <= rd_mux;
    end
  end

  // A period write restarts the countdown without disturbing the current phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler   <= RST_PERIOD;
      blink_phase <= 1'b0;
    end else if (wr_hit && offset == OFF_PERIOD) begin
      prescaler <= data_in[BLINK_W-1:0];
    end else if (period_reg == '0) begin
      prescaler   <= '0;
      blink_phase <= 1'b0;
    end else if (prescaler == '0) begin
      prescaler   <= period_reg;
      blink_phase <= ~blink_phase;
    end else begin
      prescaler <= prescaler - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
      pwm_on  <= 1'b1;
    end else begin
      pwm_cnt <= pwm_cnt + 4'd1;
      pwm_on  <= (brightness == 4'hF) | (pwm_cnt < brightness);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      leds_out    <= '0;
      sevseg_out  <= '0;
      digit_blank <= '0;
    end else begin
      leds_out    <= led_reg & {NUM_LEDS{pwm_on & ~(led_blink & blink_phase)}};
      sevseg_out  <= digits_reg;
      digit_blank <= {NUM_DIGITS{~pwm_on}} | (blink_mask & {NUM_DIGITS{blink_phase}});
    end
  end

endmodule
